// File: rtl/clk_div_cfg_ctrl_if.sv
// rtl/clk_div_cfg_ctrl_if.sv - config request handshake bundle for clk_div_cfg_ctrl
interface clk_div_cfg_ctrl_if #(
    parameter int RATIO_WIDTH = 4
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [RATIO_WIDTH-1:0] cfg_ratio;
    logic                   cfg_en;

    modport master (output cfg_valid, output cfg_ratio, output cfg_en, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ratio, input cfg_en, output cfg_ready);
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// rtl/clk_div_cfg_ctrl.sv - glitch-safe ratio/enable config stage for the clock divider (optional CFG_TIMEOUT_EN)
module clk_div_cfg_ctrl #(
    parameter int RATIO_WIDTH    = 4,
    parameter int DEFAULT_RATIO  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   ref_clk,
    input  logic                   rst_n,
    clk_div_cfg_ctrl_if.slave      cfg,
    input  logic                   div_clk,
    output logic [RATIO_WIDTH-1:0] div_ratio,
    output logic                   clk_en,
    output logic                   busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic                   timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_FALL,
        S_APPLY,
        S_SETTLE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [RATIO_WIDTH-1:0] sh_ratio;
    logic                   sh_en;
    logic                   div_q;
    logic [RATIO_WIDTH-1:0] cnt;
    logic                   fall;
    logic                   tmo_hit;
    logic                   accept;

    assign accept        = cfg.cfg_valid && (state == S_IDLE);
    assign cfg.cfg_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign fall          = div_q && !div_clk;

`ifdef CFG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES));

    // Count cycles spent waiting for a falling edge; restarts on every entry.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n)                   tcnt <= '0;
        else if (state != S_WAIT_FALL) tcnt <= '0;
        else if (!tmo_hit)            tcnt <= tcnt + TW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Previous divided-clock level for falling-edge detection.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) div_q <= 1'b0;
        else        div_q <= div_clk;
    end

    // Shadow copy of the accepted request.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ratio <= '0;
            sh_en    <= 1'b0;
        end else if (accept) begin
            sh_ratio <= cfg.cfg_ratio;
            sh_en    <= cfg.cfg_en;
        end
    end

    // State register.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Divider outputs change only in APPLY; a disable keeps the old ratio.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ratio <= RATIO_WIDTH'(DEFAULT_RATIO);
            clk_en    <= 1'b0;
        end else if (state == S_APPLY) begin
            if (sh_en) div_ratio <= sh_ratio;
            clk_en <= sh_en;
        end
    end

    // Settle counter spans one new output period after APPLY.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (state == S_APPLY)   cnt <= '0;
        else if (state == S_SETTLE)  cnt <= cnt + RATIO_WIDTH'(1);
    end

    // Next-state and single-cycle status pulses.
    always_comb begin
        state_nxt = state;
        cfg_done  = 1'b0;
        cfg_err   = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg.cfg_valid) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (sh_en && (sh_ratio < RATIO_WIDTH'(2))) begin
                    cfg_err   = 1'b1;
                    state_nxt = S_IDLE;
                end else if ((sh_en == clk_en) && (!sh_en || (sh_ratio == div_ratio))) begin
                    cfg_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (!clk_en) begin
                    state_nxt = S_APPLY;
                end else begin
                    state_nxt = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    state_nxt = S_APPLY;
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (!clk_en || (cnt == div_ratio - RATIO_WIDTH'(1))) begin
                    cfg_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// tb/tb_clk_div_cfg_ctrl.sv - directed self-checking bench for clk_div_cfg_ctrl
module tb_clk_div_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       force_hi = 1'b0;
    logic       div_clk;
    logic [3:0] div_ratio;
    logic       clk_en, busy, cfg_done, cfg_err, timeout;
    logic [3:0] dcnt;
    int         n_pass = 0;
    int         n_total = 0;

    clk_div_cfg_ctrl_if #(.RATIO_WIDTH(4)) cfg_bus ();

    clk_div_cfg_ctrl #(
        .RATIO_WIDTH(4), .DEFAULT_RATIO(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .ref_clk(clk), .rst_n(rst_n), .cfg(cfg_bus.slave), .div_clk(div_clk),
        .div_ratio(div_ratio), .clk_en(clk_en), .busy(busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Behavioural divider: low for the first half of the count, high for the rest.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       dcnt <= 4'd0;
        else if (!clk_en)                 dcnt <= 4'd0;
        else if (dcnt >= div_ratio - 4'd1) dcnt <= 4'd0;
        else                              dcnt <= dcnt + 4'd1;
    end
    assign div_clk = force_hi ? 1'b1 : (clk_en && (dcnt >= (div_ratio >> 1)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] r, input logic e);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ratio = r;
        cfg_bus.cfg_en    = e;
        tick();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!cfg_done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, cfg_done, 1'b1);
    endtask

    task automatic measure(input string tag, input int exp_period, input int exp_high);
        int  n = 0;
        int  per = 0;
        int  hi = 0;
        logic prev;
        prev = div_clk;
        while (!(!prev && div_clk) && n < 40) begin
            prev = div_clk;
            tick();
            n++;
        end
        do begin
            if (div_clk) hi++;
            prev = div_clk;
            tick();
            per++;
        end while (!(!prev && div_clk) && per < 40);
        chk({tag, "_period"}, per, exp_period);
        chk({tag, "_high"}, hi, exp_high);
    endtask

    initial begin
        int t;
        int fall_t;
        logic prev;
        logic saw_hi;

        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ratio = 4'd0;
        cfg_bus.cfg_en    = 1'b0;
        tick();
        tick();
        chk("rst_ready", cfg_bus.cfg_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ratio", div_ratio, 4'd2);
        chk("rst_clk_en", clk_en, 1'b0);
        chk("rst_pulses", {cfg_done, cfg_err, timeout}, 3'b000);
        rst_n = 1'b1;
        tick();

        // T1: disabled -> ratio 4 enabled, done six cycles after accept
        send(4'd4, 1'b1);
        chk("t1_c1_busy", busy, 1'b1);
        chk("t1_c1_ready", cfg_bus.cfg_ready, 1'b0);
        tick();
        chk("t1_c2_clk_en", clk_en, 1'b0);
        tick();
        chk("t1_c3_ratio", div_ratio, 4'd4);
        chk("t1_c3_clk_en", clk_en, 1'b1);
        tick();
        tick();
        chk("t1_c5_done", cfg_done, 1'b0);
        tick();
        chk("t1_c6_done", cfg_done, 1'b1);
        tick();
        chk("t1_c7_done", cfg_done, 1'b0);
        chk("t1_c7_ready", cfg_bus.cfg_ready, 1'b1);
        measure("t1", 4, 2);

        // T2: ratio 4 -> 6 while running; change lands two cycles after the fall
        send(4'd6, 1'b1);
        prev = div_clk;
        fall_t = -100;
        t = 1;
        while (div_ratio != 4'd6 && t < 30) begin
            tick();
            t++;
            if (prev && !div_clk && fall_t < 0) fall_t = t;
            prev = div_clk;
        end
        chk("t2_ratio", div_ratio, 4'd6);
        chk("t2_fall_to_apply", t - fall_t, 2);
        for (int i = 0; i < 5; i++) begin
            chk("t2_settle_done", cfg_done, 1'b0);
            chk("t2_settle_busy", busy, 1'b1);
            tick();
        end
        chk("t2_done", cfg_done, 1'b1);
        tick();
        measure("t2", 6, 3);

        // T3: illegal ratio rejected, outputs untouched
        send(4'd1, 1'b1);
        chk("t3_err", cfg_err, 1'b1);
        chk("t3_done", cfg_done, 1'b0);
        tick();
        chk("t3_err_low", cfg_err, 1'b0);
        chk("t3_ratio", div_ratio, 4'd6);
        chk("t3_clk_en", clk_en, 1'b1);
        chk("t3_ready", cfg_bus.cfg_ready, 1'b1);

        // T4: disable while running, then repeat the same write
        send(4'd9, 1'b0);
        t = 0;
        while (clk_en && t < 30) begin
            tick();
            t++;
        end
        chk("t4_clk_en", clk_en, 1'b0);
        chk("t4_done", cfg_done, 1'b1);
        chk("t4_ratio_kept", div_ratio, 4'd6);
        saw_hi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (div_clk) saw_hi = 1'b1;
        end
        chk("t4_div_held_low", saw_hi, 1'b0);
        send(4'd9, 1'b0);
        chk("t4_repeat_done", cfg_done, 1'b1);
        tick();
        chk("t4_repeat_idle", busy, 1'b0);

        // T6: reset during WAIT_FALL aborts the request
        send(4'd4, 1'b1);
        wait_done("t6_pre_done", 20);
        tick();
        send(4'd5, 1'b1);
        tick();
        chk("t6_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ratio", div_ratio, 4'd2);
        chk("t6_rst_clk_en", clk_en, 1'b0);
        chk("t6_rst_ready", cfg_bus.cfg_ready, 1'b1);
        chk("t6_rst_pulses", {busy, cfg_done, cfg_err, timeout}, 4'b0000);
        tick();
        tick();
        chk("t6_no_done", cfg_done, 1'b0);
        rst_n = 1'b1;
        tick();
        send(4'd5, 1'b1);
        chk("t6_accept", busy, 1'b1);
        wait_done("t6_post_done", 20);
        chk("t6_post_ratio", div_ratio, 4'd5);
        tick();

        // T5: divided clock stuck high while a ratio change waits
        force_hi = 1'b1;
        send(4'd3, 1'b1);
`ifdef CFG_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_no_timeout_yet", timeout, 1'b0);
        end
        tick();
        chk("t5_timeout", timeout, 1'b1);
        tick();
        chk("t5_timeout_low", timeout, 1'b0);
        tick();
        chk("t5_ratio", div_ratio, 4'd3);
        wait_done("t5_done", 10);
        tick();
        force_hi = 1'b0;
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5_waiting", {busy, timeout, div_ratio}, {1'b1, 1'b0, 4'd5});
        end
        force_hi = 1'b0;
        wait_done("t5_done", 20);
        chk("t5_ratio", div_ratio, 4'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
